core_div_out: RTL and testbench
===============================

# core_div_out

Result-conditioning stage at the back end of the integer divider. It captures each divide's signedness context at issue, waits for the unsigned magnitude core to finish, then produces the architectural result. That result is the sign-corrected quotient or remainder, with 32-bit word results sign-extended. The stage also resolves divide-by-zero and signed overflow per the RISC-V M extension, and presents the result on a valid/ready handshake to writeback.

## Interface
- XLEN, 64, datapath width; word ops use bits XLEN/2-1:0
- i_clk  in  1  clock; all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_div_out_start  in  1  issue pulse; context captured only when state is IDLE
- i_div_out_srcA  in  XLEN  original (unconditioned) dividend at issue
- i_div_out_srcB  in  XLEN  original (unconditioned) divisor at issue
- i_div_out_control  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (W forms when isword)
- i_div_out_isword  in  1  32-bit word operation
- i_div_out_flush  in  1  abort current operation
- i_div_out_done  in  1  unsigned core finished; magnitudes valid this cycle
- i_div_out_quotient  in  XLEN  unsigned quotient magnitude
- i_div_out_remainder  in  XLEN  unsigned remainder magnitude
- i_div_out_ready  in  1  writeback accepts result
- o_div_out_busy  out  1  state != IDLE
- o_div_out_valid  out  1  result held and valid
- o_div_out_result  out  XLEN  final result

## Operation
- Effective sign bits: sA/sB = bit XLEN-1, or bit XLEN/2-1 when isword. Signed op = control[0]==0.
- At accepted start, register control, isword, sA, sB, dividend (low half sign-extended when isword), and the following flags:
  - dz: divisor in effective width == 0.
  - ovf: signed op, dividend == most-negative of effective width, divisor == all ones in effective width.
  - neg_q: signed op & (sA ^ sB).
  - neg_r: signed op & sA.
- States: IDLE, BUSY, HOLD.
  - IDLE → HOLD on start with dz|ovf, because the special result needs no core.
  - IDLE → BUSY on start otherwise.
  - BUSY → HOLD on done, registering the computed result.
  - HOLD → IDLE on ready.
  - Flush in any state → IDLE.
- Result computation:
  - Quotient ops: quotient magnitude, two's-complement negated if neg_q.
  - Remainder ops: remainder magnitude, negated if neg_r.
  - When isword, take bits XLEN/2-1:0 of the corrected value and sign-extend bit XLEN/2-1 to XLEN. This applies to DIVUW/REMUW as well.
- Special results:
  - dz: quotient = all ones; remainder = dividend (word: sign-extended low half).
  - ovf: quotient = dividend; remainder = 0.
- Boundary behaviour:
  - start while not IDLE is ignored.
  - done in IDLE or HOLD is ignored.
  - start and flush in the same cycle: flush wins, nothing captured.
  - flush with ready in HOLD: flush wins, result dropped.
  - Reset mid-operation returns to IDLE, discarding context.

## Timing
- Reset values: state IDLE, o_div_out_valid 0, o_div_out_busy 0, o_div_out_result 0, all context registers 0.
- Special cases: valid rises the cycle after start (1-cycle latency).
- Normal cases: valid rises the cycle after done.
- result is registered and stable while valid & !ready; valid falls the cycle after ready is sampled high.
- busy falls the cycle after the handshake, so back-to-back issue costs at least one IDLE cycle.
- Flush: valid/busy low the following cycle.
- No combinational path from any input to any output.

## Structure
- Shared package core_div_pkg holds:
  - Opcode localparams DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW, shared with the input conditioner.
  - State enum div_out_state_t {IDLE, BUSY, HOLD}.
- One combinational sub-module, core_div_out_fix: takes magnitude, negate flag, and isword, and returns the corrected XLEN result. The FSM, context registers, and special-case mux stay in core_div_out.

## Test plan
- DIV -7 / 2: start, done after 5 cycles with quotient 3, remainder 1 → result 0xFFFFFFFFFFFFFFFD one cycle after done. REM on the same operands → 0xFFFFFFFFFFFFFFFF.
- DIVU 0x1234 / 0 → valid one cycle after start, no done needed, result 0xFFFFFFFFFFFFFFFF. REMU on the same operands → 0x1234.
- DIV 0x8000000000000000 / -1 → result 0x8000000000000000. REM on the same operands → 0. DIVW 0x80000000 / 0xFFFFFFFF → 0xFFFFFFFF80000000.
- DIVW srcA 0x00000000FFFFFFF9, srcB 2; core returns quotient 3 → 0xFFFFFFFFFFFFFFFD. DIVUW 0xFFFFFFFF / 1, core quotient 0xFFFFFFFF → 0xFFFFFFFFFFFFFFFF.
- Backpressure: hold ready low for 4 cycles in HOLD → result and valid stable. A start pulse in that window is ignored. Ready high → valid low the next cycle.
- Flush in BUSY, then done arrives → valid never rises and busy is low the cycle after flush. Async reset asserted in HOLD → outputs zero immediately.

Source files
------------

// File: rtl/core_div_pkg.sv
// Shared divider definitions: datapath width, opcode encodings and the
// result-stage state type.
package core_div_pkg;

  localparam int XLEN = 64;
  localparam int HALF = XLEN / 2;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  // Word forms: {isword, control}
  localparam logic [2:0] DIVW  = {1'b1, DIV};
  localparam logic [2:0] DIVUW = {1'b1, DIVU};
  localparam logic [2:0] REMW  = {1'b1, REM};
  localparam logic [2:0] REMUW = {1'b1, REMU};

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} div_out_state_t;

endpackage

// File: rtl/core_div_out_fix.sv
// Sign correction of an unsigned divider magnitude, with word-result
// sign extension from bit HALF-1.
module core_div_out_fix
  import core_div_pkg::*;
(
  input  logic [XLEN-1:0] mag,
  input  logic            neg,
  input  logic            isword,
  output logic [XLEN-1:0] res
);

  logic [XLEN-1:0] corr;

  // NOTE: every variable is assigned on every path, so no latch is inferred.
  always_comb begin
    corr = neg ? (~mag + XLEN'(1)) : mag;
    res  = isword ? {{HALF{corr[HALF-1]}}, corr[HALF-1:0]} : corr;
  end

endmodule

// File: rtl/core_div_out.sv
// Divider back end: captures signedness context at issue, conditions the
// core's magnitudes into the architectural result, handshakes to writeback.
module core_div_out
  import core_div_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_div_out_start,
  input  logic [XLEN-1:0] i_div_out_srcA,
  input  logic [XLEN-1:0] i_div_out_srcB,
  input  logic [1:0]      i_div_out_control,
  input  logic            i_div_out_isword,
  input  logic            i_div_out_flush,
  input  logic            i_div_out_done,
  input  logic [XLEN-1:0] i_div_out_quotient,
  input  logic [XLEN-1:0] i_div_out_remainder,
  input  logic            i_div_out_ready,
  output logic            o_div_out_busy,
  output logic            o_div_out_valid,
  output logic [XLEN-1:0] o_div_out_result
);

  div_out_state_t  state;
  logic [1:0]      ctl_q;
  logic            isword_q, sa_q, sb_q, dz_q, ovf_q;
  logic [XLEN-1:0] dividend_q, core_res_q;
  logic            valid_q, busy_q;

  // Issue-time decode of the raw operands
  logic [HALF-1:0] a_lo, b_lo;
  logic            signed_d, sa_d, sb_d, dz_d, ovf_d;
  logic [XLEN-1:0] dividend_d;

  always_comb begin
    a_lo       = i_div_out_srcA[HALF-1:0];
    b_lo       = i_div_out_srcB[HALF-1:0];
    signed_d   = (i_div_out_control == DIV) || (i_div_out_control == REM);
    sa_d       = i_div_out_isword ? a_lo[HALF-1] : i_div_out_srcA[XLEN-1];
    sb_d       = i_div_out_isword ? b_lo[HALF-1] : i_div_out_srcB[XLEN-1];
    dividend_d = i_div_out_isword ? {{HALF{a_lo[HALF-1]}}, a_lo} : i_div_out_srcA;
    dz_d       = i_div_out_isword ? (b_lo == '0) : (i_div_out_srcB == '0);
    if (i_div_out_isword)
      ovf_d = signed_d && (a_lo == {1'b1, {(HALF-1){1'b0}}}) && (b_lo == '1);
    else
      ovf_d = signed_d && (i_div_out_srcA == {1'b1, {(XLEN-1){1'b0}}})
                       && (i_div_out_srcB == '1);
  end

  // Sign-correction flags derived from the captured context
  logic            is_rem, signed_q, neg_quo, neg_rem;
  logic [XLEN-1:0] fix_res, special_res;

  assign is_rem   = (ctl_q == REM) || (ctl_q == REMU);
  assign signed_q = (ctl_q == DIV) || (ctl_q == REM);
  assign neg_quo  = signed_q & (sa_q ^ sb_q);
  assign neg_rem  = signed_q & sa_q;

  core_div_out_fix u_fix (
    .mag    (is_rem ? i_div_out_remainder : i_div_out_quotient),
    .neg    (is_rem ? neg_rem : neg_quo),
    .isword (isword_q),
    .res    (fix_res)
  );

  // Special results come purely from captured registers, so they are ready
  // the cycle after issue without any input-to-output path.
  always_comb begin
    if (dz_q) special_res = is_rem ? dividend_q : '1;
    else      special_res = is_rem ? '0 : dividend_q;
  end

  assign o_div_out_result = (dz_q | ovf_q) ? special_res : core_res_q;
  assign o_div_out_valid  = valid_q;
  assign o_div_out_busy   = busy_q;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      ctl_q      <= '0;
      isword_q   <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      dividend_q <= '0;
      core_res_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else if (i_div_out_flush) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_div_out_start) begin
          ctl_q      <= i_div_out_control;
          isword_q   <= i_div_out_isword;
          sa_q       <= sa_d;
          sb_q       <= sb_d;
          dz_q       <= dz_d;
          ovf_q      <= ovf_d;
          dividend_q <= dividend_d;
          busy_q     <= 1'b1;
          if (dz_d || ovf_d) begin
            state   <= HOLD;
            valid_q <= 1'b1;
          end else begin
            state <= BUSY;
          end
        end
        BUSY: if (i_div_out_done) begin
          core_res_q <= fix_res;
          state      <= HOLD;
          valid_q    <= 1'b1;
        end
        HOLD: if (i_div_out_ready) begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_div_out.sv
// Directed bench for core_div_out with a result scoreboard queue.
module tb_core_div_out;
  import core_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, isword = 1'b0, flush = 1'b0, done = 1'b0, ready = 1'b0;
  logic [1:0]  control = 2'b00;
  logic [63:0] src_a = '0, src_b = '0, quotient = '0, remainder = '0;
  logic        busy, valid;
  logic [63:0] result;

  int total = 0;
  int passed = 0;
  logic [63:0] exp_q[$];

  core_div_out dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_div_out_start     (start),
    .i_div_out_srcA      (src_a),
    .i_div_out_srcB      (src_b),
    .i_div_out_control   (control),
    .i_div_out_isword    (isword),
    .i_div_out_flush     (flush),
    .i_div_out_done      (done),
    .i_div_out_quotient  (quotient),
    .i_div_out_remainder (remainder),
    .i_div_out_ready     (ready),
    .o_div_out_busy      (busy),
    .o_div_out_valid     (valid),
    .o_div_out_result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      e = 'x;
      check({tag, " (scoreboard empty)"}, result, e);
    end else begin
      e = exp_q.pop_front();
      check(tag, result, e);
    end
  endtask

  // Drive a start pulse at a negedge; returns at the negedge after capture.
  task automatic drive_start(input logic [1:0] c, input logic w,
                             input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    start = 1'b1; control = c; isword = w; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic accept(input string tag);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check({tag, " valid after ready"}, 64'(valid), 64'd0);
    check({tag, " busy after ready"}, 64'(busy), 64'd0);
  endtask

  task automatic run_special(input string tag, input logic [1:0] c, input logic w,
                             input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] exp);
    exp_q.push_back(exp);
    drive_start(c, w, a, b);
    check({tag, " valid 1 cycle after start"}, 64'(valid), 64'd1);
    pop_check({tag, " result"});
    accept(tag);
  endtask

  task automatic run_normal(input string tag, input logic [1:0] c, input logic w,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] q, input logic [63:0] r,
                            input logic [63:0] exp, input bit do_accept);
    exp_q.push_back(exp);
    drive_start(c, w, a, b);
    check({tag, " busy after start"}, 64'(busy), 64'd1);
    repeat (3) @(negedge clk);
    check({tag, " valid before done"}, 64'(valid), 64'd0);
    done = 1'b1; quotient = q; remainder = r;
    @(negedge clk);
    done = 1'b0;
    check({tag, " valid 1 cycle after done"}, 64'(valid), 64'd1);
    pop_check({tag, " result"});
    if (do_accept) accept(tag);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset valid", 64'(valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset result", result, 64'd0);
    rst_n = 1'b1;

    // done while IDLE is ignored
    @(negedge clk);
    done = 1'b1; quotient = 64'd9;
    @(negedge clk);
    done = 1'b0;
    check("done in idle valid", 64'(valid), 64'd0);
    check("done in idle busy", 64'(busy), 64'd0);

    run_normal("DIV -7/2", DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
    run_normal("REM -7/2", REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_special("DIVU x/0", DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_special("REMU x/0", REMU, 1'b0, 64'h1234, 64'd0, 64'h1234);
    run_special("DIV ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, '1,
                64'h8000_0000_0000_0000);
    run_special("REM ovf", REM, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0);
    run_special("DIVW ovf", DIVW[1:0], DIVW[2], 64'h0000_0000_8000_0000,
                64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    run_special("REMUW x/0", REMUW[1:0], REMUW[2], 64'h0000_0000_8000_0000,
                64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);
    run_normal("DIVW -7/2", DIVW[1:0], DIVW[2], 64'h0000_0000_FFFF_FFF9, 64'd2,
               64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
    run_normal("REMW -7/2", REMW[1:0], REMW[2], 64'h0000_0000_FFFF_FFF9, 64'd2,
               64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_normal("DIVUW", DIVUW[1:0], DIVUW[2], 64'h0000_0000_FFFF_FFFF, 64'd1,
               64'h0000_0000_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    // Backpressure: result held 4 cycles, a start in the window is ignored
    run_normal("DIV 100/7", DIV, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 64'd14, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        start = 1'b1; control = DIVU; isword = 1'b0; src_a = 64'd5; src_b = 64'd0;
      end
      @(negedge clk);
      start = 1'b0;
      check($sformatf("hold valid c%0d", i), 64'(valid), 64'd1);
      check($sformatf("hold result c%0d", i), result, 64'd14);
    end
    accept("backpressure");
    @(negedge clk);
    check("ignored start stays idle", 64'(valid | busy), 64'd0);

    // Flush in BUSY, then a late done
    drive_start(DIV, 1'b0, 64'd50, 64'd5);
    check("pre-flush busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush valid", 64'(valid), 64'd0);
    done = 1'b1; quotient = 64'd10;
    @(negedge clk);
    done = 1'b0;
    check("late done valid", 64'(valid), 64'd0);
    check("late done busy", 64'(busy), 64'd0);

    // start and flush together: nothing captured
    @(negedge clk);
    start = 1'b1; flush = 1'b1; control = DIVU; src_a = 64'd3; src_b = 64'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start+flush busy", 64'(busy), 64'd0);
    check("start+flush valid", 64'(valid), 64'd0);

    // flush with ready in HOLD: result dropped
    drive_start(DIVU, 1'b0, 64'd3, 64'd0);
    check("pre-flush hold valid", 64'(valid), 64'd1);
    ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    ready = 1'b0; flush = 1'b0;
    check("flush+ready valid", 64'(valid), 64'd0);
    check("flush+ready busy", 64'(busy), 64'd0);

    // Async reset while in HOLD
    drive_start(DIVU, 1'b0, 64'd5, 64'd0);
    check("pre-reset valid", 64'(valid), 64'd1);
    check("pre-reset result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    #1 rst_n = 1'b0;
    #1;
    check("async reset valid", 64'(valid), 64'd0);
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after reset idle", 64'(valid | busy), 64'd0);

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
